// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : fpu_pkg
//  Purpose   : Shared constants and stage payload types for the FPU
//              float-to-integer converters.
//  Revision  : 1.0  initial release
// ============================================================================
package fpu_pkg;

   // Resolved RISC-V rounding modes
   localparam logic [2:0] RM_RNE = 3'b000;
   localparam logic [2:0] RM_RTZ = 3'b001;
   localparam logic [2:0] RM_RDN = 3'b010;
   localparam logic [2:0] RM_RUP = 3'b011;
   localparam logic [2:0] RM_RMM = 3'b100;

   // Bit positions inside the {NV,DZ,OF,UF,NX} flag vector
   localparam int FLAG_NV = 4;
   localparam int FLAG_NX = 0;

   localparam logic [31:0] UINT_MAX = 32'hFFFF_FFFF;
   localparam int          EXP_BIAS = 127;

   // Unpacked operand after classification
   typedef struct packed {
      logic        sign;
      logic        is_nan;
      logic        is_inf;
      logic [9:0]  exp_unb;   // two's complement unbiased exponent
      logic [23:0] sig;       // hidden bit plus fraction
      logic [2:0]  rm;
   } s1_payload_t;

   // Aligned integer part with rounding information
   typedef struct packed {
      logic        sign;
      logic        is_nan;
      logic        is_inf;
      logic        ovf;       // exponent too large for any 32-bit integer
      logic [31:0] int_part;
      logic        guard;
      logic        sticky;
      logic [2:0]  rm;
   } s2_payload_t;

endpackage : fpu_pkg
`default_nettype wire

// File: rtl/fpu_round_inc.sv
`default_nettype none
// ============================================================================
//  Module    : fpu_round_inc
//  Purpose   : Decides whether a truncated magnitude must be incremented,
//              given the rounding mode, sign, lsb, guard and sticky bits.
//  Revision  : 1.0  initial release
// ============================================================================
module fpu_round_inc
   import fpu_pkg::*;
(
   input  logic [2:0] rm,
   input  logic       sign,
   input  logic       lsb,
   input  logic       guard,
   input  logic       sticky,
   output logic       inc
);

   // Reserved encodings fall back to round-to-nearest-even
   always_comb begin
      inc = 1'b0;
      case (rm)
         RM_RTZ:  inc = 1'b0;
         RM_RDN:  inc = sign & (guard | sticky);
         RM_RUP:  inc = ~sign & (guard | sticky);
         RM_RMM:  inc = guard;
         default: inc = guard & (sticky | lsb);
      endcase
   end

endmodule : fpu_round_inc
`default_nettype wire

// File: rtl/fcvt_wu_s_pipe.sv
`default_nettype none
// ============================================================================
//  Module    : fcvt_wu_s_pipe
//  Purpose   : Three-stage pipelined FCVT.WU.S (single float -> uint32)
//              with valid/ready handshake, full backpressure, tag pass-through.
//  Revision  : 1.0  initial release
// ============================================================================
module fcvt_wu_s_pipe
   import fpu_pkg::*;
#(
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_num,
   input  logic [2:0]       in_rm,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_num,
   output logic [4:0]       out_flags,
   output logic [TAG_W-1:0] out_tag
);

   // Whole pipe moves together; it only freezes when the output is blocked
   logic adv;
   assign adv      = ~out_valid | out_ready;
   assign in_ready = adv;

   // ---------------------------------------------------------------- S1
   logic [7:0]        exp_in;
   logic [22:0]       frac_in;
   logic signed [9:0] e_in;
   s1_payload_t       s1_d;

   // Unpack and classify the incoming operand
   always_comb begin
      exp_in  = in_num[30:23];
      frac_in = in_num[22:0];
      e_in    = (exp_in == 8'd0) ? -10'sd126
                                 : (signed'({2'b00, exp_in}) - signed'(10'(EXP_BIAS)));
      s1_d.sign    = in_num[31];
      s1_d.is_nan  = (exp_in == 8'hFF) && (frac_in != 23'd0);
      s1_d.is_inf  = (exp_in == 8'hFF) && (frac_in == 23'd0);
      s1_d.exp_unb = e_in;
      s1_d.sig     = {exp_in != 8'd0, frac_in};
      s1_d.rm      = in_rm;
   end

   logic             s1_valid;
   s1_payload_t      s1_q;
   logic [TAG_W-1:0] s1_tag;

   // Stage 1 register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_q     <= '0;
         s1_tag   <= '0;
      end else if (adv) begin
         s1_valid <= in_valid;
         s1_q     <= s1_d;
         s1_tag   <= in_tag;
      end
   end

   // ---------------------------------------------------------------- S2
   // The significand is placed at the top of a 56-bit window holding
   // 32 integer and 24 fraction bits for E = 31; shifting right by 31-E
   // aligns any E in [-1, 31] without losing bits.
   logic signed [9:0] e_s2;
   logic [5:0]        shamt;
   logic [55:0]       shifted;
   s2_payload_t       s2_d;

   // Align the significand to an integer plus guard/sticky
   always_comb begin
      e_s2    = signed'(s1_q.exp_unb);
      shamt   = 6'd31 - s1_q.exp_unb[5:0];
      shifted = {s1_q.sig, 32'd0} >> shamt;

      s2_d.sign     = s1_q.sign;
      s2_d.is_nan   = s1_q.is_nan;
      s2_d.is_inf   = s1_q.is_inf;
      s2_d.rm       = s1_q.rm;
      s2_d.ovf      = 1'b0;
      s2_d.int_part = 32'd0;
      s2_d.guard    = 1'b0;
      s2_d.sticky   = 1'b0;

      if (e_s2 >= 10'sd32) begin
         s2_d.ovf = 1'b1;
      end else if (e_s2 >= -10'sd1) begin
         s2_d.int_part = shifted[55:24];
         s2_d.guard    = shifted[23];
         s2_d.sticky   = |shifted[22:0];
      end else begin
         s2_d.sticky   = |s1_q.sig;
      end
   end

   logic             s2_valid;
   s2_payload_t      s2_q;
   logic [TAG_W-1:0] s2_tag;

   // Stage 2 register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_q     <= '0;
         s2_tag   <= '0;
      end else if (adv) begin
         s2_valid <= s1_valid;
         s2_q     <= s2_d;
         s2_tag   <= s1_tag;
      end
   end

   // ---------------------------------------------------------------- S3
   logic        inc;
   logic [32:0] mag;
   logic        inexact;
   logic [31:0] res_num;
   logic [4:0]  res_flags;

   fpu_round_inc u_round_inc (
      .rm     (s2_q.rm),
      .sign   (s2_q.sign),
      .lsb    (s2_q.int_part[0]),
      .guard  (s2_q.guard),
      .sticky (s2_q.sticky),
      .inc    (inc)
   );

   // Round, then saturate with invalid taking precedence over inexact
   always_comb begin
      mag       = {1'b0, s2_q.int_part} + {32'd0, inc};
      inexact   = s2_q.guard | s2_q.sticky;
      res_num   = 32'd0;
      res_flags = 5'd0;
      if (s2_q.is_nan || (s2_q.is_inf && !s2_q.sign)) begin
         res_num            = UINT_MAX;
         res_flags[FLAG_NV] = 1'b1;
      end else if (s2_q.is_inf) begin
         res_flags[FLAG_NV] = 1'b1;
      end else if (!s2_q.sign && (s2_q.ovf || mag[32])) begin
         res_num            = UINT_MAX;
         res_flags[FLAG_NV] = 1'b1;
      end else if (s2_q.sign && (s2_q.ovf || (mag != 33'd0))) begin
         res_flags[FLAG_NV] = 1'b1;
      end else if (s2_q.sign) begin
         res_flags[FLAG_NX] = inexact;
      end else begin
         res_num            = mag[31:0];
         res_flags[FLAG_NX] = inexact;
      end
   end

   // Output register; holds its value while the consumer stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_num   <= 32'd0;
         out_flags <= 5'd0;
         out_tag   <= '0;
      end else if (adv) begin
         out_valid <= s2_valid;
         out_num   <= res_num;
         out_flags <= res_flags;
         out_tag   <= s2_tag;
      end
   end

endmodule : fcvt_wu_s_pipe
`default_nettype wire

// File: tb/tb_fcvt_wu_s_pipe.sv
`default_nettype none
// ============================================================================
//  Module    : tb_fcvt_wu_s_pipe
//  Purpose   : Directed, table-driven bench for fcvt_wu_s_pipe.
//  Revision  : 1.0  initial release
// ============================================================================
module tb_fcvt_wu_s_pipe;

   localparam logic [2:0] RNE = 3'b000, RTZ = 3'b001, RDN = 3'b010,
                          RUP = 3'b011, RMM = 3'b100;
   localparam logic [4:0] F_NONE = 5'b00000, F_NV = 5'b10000, F_NX = 5'b00001;

   typedef struct {
      logic [31:0] num;
      logic [2:0]  rm;
      logic [31:0] res;
      logic [4:0]  flags;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_num = 32'd0;
   logic [2:0]  in_rm = 3'd0;
   logic [4:0]  in_tag = 5'd0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_num;
   logic [4:0]  out_flags;
   logic [4:0]  out_tag;

   int total = 0;
   int bad   = 0;

   fcvt_wu_s_pipe #(.TAG_W(5)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_num    (in_num),
      .in_rm     (in_rm),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_num   (out_num),
      .out_flags (out_flags),
      .out_tag   (out_tag)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Present one operand, wait for its result, check latency and contents
   task automatic run_vec(input vec_t v, input logic [4:0] tag);
      int lat;
      lat = 0;
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_num    = v.num;
      in_rm     = v.rm;
      in_tag    = tag;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 1) in_valid = 1'b0;
         if (out_valid && lat == 0) begin
            lat = k;
            break;
         end
      end
      check($sformatf("latency[%0d]", tag), lat, 3);
      if (lat != 0) begin
         check($sformatf("num[%0d] %h", tag, v.num), out_num, v.res);
         check($sformatf("flags[%0d] %h", tag, v.num), {27'd0, out_flags}, {27'd0, v.flags});
         check($sformatf("tag[%0d]", tag), {27'd0, out_tag}, {27'd0, tag});
      end
   endtask

   vec_t vecs[$];
   logic [31:0] ftab [6];

   initial begin
      int sent, rcvd, cyc, ir_low, extra;
      logic stalled_prev;
      logic [31:0] pn;
      logic [4:0]  pf, pt;

      vecs.push_back('{32'h40490FDB, RNE, 32'd3,         F_NX});
      vecs.push_back('{32'h3FC00000, RNE, 32'd2,         F_NX});
      vecs.push_back('{32'h40200000, RNE, 32'd2,         F_NX});
      vecs.push_back('{32'h4F7FFFFF, RNE, 32'hFFFFFF00,  F_NONE});
      vecs.push_back('{32'h3F000000, RNE, 32'd0,         F_NX});
      vecs.push_back('{32'h3F000000, RTZ, 32'd0,         F_NX});
      vecs.push_back('{32'h3F000000, RDN, 32'd0,         F_NX});
      vecs.push_back('{32'h3F000000, RUP, 32'd1,         F_NX});
      vecs.push_back('{32'h3F000000, RMM, 32'd1,         F_NX});
      vecs.push_back('{32'h40200000, RMM, 32'd3,         F_NX});
      vecs.push_back('{32'h4F800000, RNE, 32'hFFFFFFFF,  F_NV});
      vecs.push_back('{32'h7F800000, RNE, 32'hFFFFFFFF,  F_NV});
      vecs.push_back('{32'h7FC00000, RNE, 32'hFFFFFFFF,  F_NV});
      vecs.push_back('{32'h7F800001, RNE, 32'hFFFFFFFF,  F_NV});
      vecs.push_back('{32'hFF800000, RNE, 32'd0,         F_NV});
      vecs.push_back('{32'hBF800000, RNE, 32'd0,         F_NV});
      vecs.push_back('{32'hBE800000, RNE, 32'd0,         F_NX});
      vecs.push_back('{32'hBE800000, RDN, 32'd0,         F_NV});
      vecs.push_back('{32'h80000000, RNE, 32'd0,         F_NONE});
      vecs.push_back('{32'h00000001, RUP, 32'd1,         F_NX});
      vecs.push_back('{32'hCF800000, RTZ, 32'd0,         F_NV});
      vecs.push_back('{32'h3F800000, RNE, 32'd1,         F_NONE});
      vecs.push_back('{32'h3FFFFFFF, RTZ, 32'd1,         F_NX});
      vecs.push_back('{32'h3FFFFFFF, RNE, 32'd2,         F_NX});
      vecs.push_back('{32'h4F7FFFFF, RUP, 32'hFFFFFF00,  F_NONE});
      vecs.push_back('{32'h00000000, RUP, 32'd0,         F_NONE});
      vecs.push_back('{32'h40200000, 3'b101, 32'd2,      F_NX});
      vecs.push_back('{32'h3F400000, RDN, 32'd0,         F_NX});
      vecs.push_back('{32'hBF400000, RUP, 32'd0,         F_NX});
      vecs.push_back('{32'h4B000001, RNE, 32'h00800001,  F_NONE});

      ftab = '{32'h3F800000, 32'h40000000, 32'h40400000,
               32'h40800000, 32'h40A00000, 32'h40C00000};

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst out_valid", {31'd0, out_valid}, 32'd0);
      check("rst out_num", out_num, 32'd0);
      check("rst out_flags", {27'd0, out_flags}, 32'd0);
      check("rst out_tag", {27'd0, out_tag}, 32'd0);
      rst_n = 1'b1;
      #1;
      check("rst in_ready", {31'd0, in_ready}, 32'd1);

      // Table of single conversions
      for (int i = 0; i < vecs.size(); i++) begin
         run_vec(vecs[i], 5'(i));
      end

      // Backpressure: six back-to-back operands, consumer stalls 4 cycles
      sent = 0; rcvd = 0; cyc = 0; ir_low = 0;
      stalled_prev = 1'b0; pn = '0; pf = '0; pt = '0;
      while (rcvd < 6 && cyc < 40) begin
         @(negedge clk);
         cyc++;
         out_ready = !(cyc >= 5 && cyc <= 8);
         #1;
         if (stalled_prev) begin
            check("bp hold valid", {31'd0, out_valid}, 32'd1);
            check("bp hold num", out_num, pn);
            check("bp hold flags", {27'd0, out_flags}, {27'd0, pf});
            check("bp hold tag", {27'd0, out_tag}, {27'd0, pt});
         end
         check("bp in_ready", {31'd0, in_ready}, {31'd0, !(out_valid && !out_ready)});
         if (!in_ready) ir_low++;
         if (out_valid && out_ready) begin
            check("bp tag order", {27'd0, out_tag}, rcvd + 1);
            check("bp num", out_num, rcvd + 1);
            check("bp flags", {27'd0, out_flags}, 32'd0);
            rcvd++;
         end
         stalled_prev = out_valid && !out_ready;
         pn = out_num; pf = out_flags; pt = out_tag;
         if (sent < 6) begin
            in_valid = 1'b1;
            in_num   = ftab[sent];
            in_rm    = RNE;
            in_tag   = 5'(sent + 1);
            if (in_ready) sent++;
         end else begin
            in_valid = 1'b0;
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("bp received", rcvd, 6);
      check("bp in_ready low cycles", ir_low, 4);
      extra = 0;
      repeat (5) begin
         @(negedge clk);
         if (out_valid) extra++;
      end
      check("bp duplicates", extra, 0);

      // Reset with operands in flight
      @(negedge clk);
      in_valid = 1'b1; in_num = 32'h3F800000; in_rm = RNE; in_tag = 5'd7;
      @(negedge clk);
      in_num = 32'h40000000; in_tag = 5'd8;
      @(negedge clk);
      in_num = 32'h40400000; in_tag = 5'd9;
      @(negedge clk);
      in_valid = 1'b0;
      check("pre-reset out_valid", {31'd0, out_valid}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("reset drops out_valid", {31'd0, out_valid}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      extra = 0;
      repeat (6) begin
         @(negedge clk);
         if (out_valid) extra++;
      end
      check("no stale after reset", extra, 0);
      run_vec('{32'h40A00000, RNE, 32'd5, F_NONE}, 5'd10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_fcvt_wu_s_pipe
`default_nettype wire
